// File: rtl/delay_line_ctrl.sv
// Per-sample sequencer for the guitar-effect delay line: clears the sample RAM,
// then runs read / mix / write-back for each accepted sample in echo, slapback or bypass.
module delay_line_ctrl #(
  parameter int B = 15,
  parameter int T = 20000
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic [3:0]    options_i,
  input  logic [B-1:0]  delay_len_i,
  input  logic [31:0]   x_i,
  input  logic          x_valid_i,
  output logic          ready_o,
  output logic [31:0]   y_o,
  output logic          y_valid_o,
  output logic          ram_we_o,
  output logic [B-1:0]  ram_addr_wr_o,
  output logic [B-1:0]  ram_addr_rd_o,
  output logic [31:0]   ram_di_o,
  input  logic [31:0]   ram_do_i
);

  localparam int            LW   = B + 1;
  localparam logic [LW-1:0] TL   = LW'(T);
  localparam logic [B-1:0]  LAST = B'(T - 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD,
    MIX,
    WR
  } state_t;

  state_t        state_q, state_d;
  logic          clrArm_q;
  logic [B-1:0]  clrCnt_q, clrCnt_d;
  logic [B-1:0]  wrPtr_q, wrPtr_d;
  logic [31:0]   x_q, x_d;
  logic          en_q, en_d;
  logic [3:0]    opt_q, opt_d;
  logic [LW-1:0] len_q, len_d;
  logic [31:0]   y_q, y_d;
  logic [31:0]   wb_q, wb_d;

  logic [LW-1:0] lenIn, lenClamped;
  logic [LW-1:0] ptrExt, rdFull;
  logic signed [31:0] dHalf;
  logic [32:0]   mixSum;
  logic [31:0]   satSum;

  always_comb begin
    lenIn = {1'b0, delay_len_i};
    if (lenIn == '0) begin
      lenClamped = LW'(1);
    end else if (lenIn > TL) begin
      lenClamped = TL;
    end else begin
      lenClamped = lenIn;
    end
  end

  // Read address wraps by adding T instead of letting the subtraction underflow.
  always_comb begin
    ptrExt = {1'b0, wrPtr_q};
    if (ptrExt >= len_q) begin
      rdFull = ptrExt - len_q;
    end else begin
      rdFull = ptrExt + TL - len_q;
    end
  end

  assign dHalf  = $signed(ram_do_i) >>> 1;
  assign mixSum = {x_q[31], x_q} + {dHalf[31], dHalf};

  always_comb begin
    if (mixSum[32] != mixSum[31]) begin
      satSum = mixSum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      satSum = mixSum[31:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    wrPtr_d  = wrPtr_q;
    x_d      = x_q;
    en_d     = en_q;
    opt_d    = opt_q;
    len_d    = len_q;
    y_d      = y_q;
    wb_d     = wb_q;

    case (state_q)
      CLEAR: begin
        if (clrArm_q) begin
          if (clrCnt_q == LAST) begin
            clrCnt_d = '0;
            state_d  = IDLE;
          end else begin
            clrCnt_d = clrCnt_q + 1'b1;
          end
        end
      end
      IDLE: begin
        if (x_valid_i) begin
          x_d     = x_i;
          en_d    = en_i;
          opt_d   = options_i;
          len_d   = lenClamped;
          state_d = RD;
        end
      end
      RD: begin
        state_d = MIX;
      end
      MIX: begin
        y_d  = x_q;
        wb_d = x_q;
        if (en_q) begin
          if (opt_q == 4'b1000) begin
            y_d  = satSum;
            wb_d = satSum;
          end else if (opt_q == 4'b0100) begin
            y_d  = satSum;
          end
        end
        state_d = WR;
      end
      WR: begin
        if (en_q) begin
          wrPtr_d = (wrPtr_q == LAST) ? '0 : wrPtr_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // clrArm_q keeps the clear writes off while reset is still asserted.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= CLEAR;
      clrArm_q <= 1'b0;
      clrCnt_q <= '0;
      wrPtr_q  <= '0;
      x_q      <= '0;
      en_q     <= 1'b0;
      opt_q    <= '0;
      len_q    <= LW'(1);
      y_q      <= '0;
      wb_q     <= '0;
    end else begin
      state_q  <= state_d;
      clrArm_q <= 1'b1;
      clrCnt_q <= clrCnt_d;
      wrPtr_q  <= wrPtr_d;
      x_q      <= x_d;
      en_q     <= en_d;
      opt_q    <= opt_d;
      len_q    <= len_d;
      y_q      <= y_d;
      wb_q     <= wb_d;
    end
  end

  assign ready_o       = (state_q == IDLE);
  assign y_valid_o     = (state_q == WR);
  assign y_o           = y_q;
  assign ram_we_o      = ((state_q == CLEAR) && clrArm_q) || ((state_q == WR) && en_q);
  assign ram_addr_wr_o = (state_q == CLEAR) ? clrCnt_q : wrPtr_q;
  assign ram_addr_rd_o = rdFull[B-1:0];
  assign ram_di_o      = (state_q == CLEAR) ? 32'h0 : wb_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl with T=8: vector table plus scoreboard of expected outputs,
// checked against a behavioural RAM and an independent history model.
module tb_delay_line_ctrl;

  localparam int B = 4;
  localparam int T = 8;

  logic          clk;
  logic          rstN;
  logic          en;
  logic [3:0]    options;
  logic [B-1:0]  delayLen;
  logic [31:0]   x;
  logic          xValid;
  logic          ready;
  logic [31:0]   y;
  logic          yValid;
  logic          ramWe;
  logic [B-1:0]  ramAddrWr;
  logic [B-1:0]  ramAddrRd;
  logic [31:0]   ramDi;
  logic [31:0]   ramDo;

  logic [31:0]   mem [0:(1<<B)-1];

  typedef struct {
    logic [31:0] y;
    logic [31:0] wb;
    bit          en;
    int          wrAddr;
    int          accN;
  } exp_t;

  typedef struct {
    bit          resetBefore;
    logic [31:0] x;
    bit          en;
    logic [3:0]  opt;
    int          dl;
    int          lEff;
    logic [31:0] expY;
  } vec_t;

  exp_t        sbQ[$];
  logic [31:0] hist[$];
  int          ptrM;
  int          cycleCnt;
  int          errors;
  int          checks;
  bit          clearing;
  vec_t        vecs[$];

  delay_line_ctrl #(.B(B), .T(T)) dut (
    .clk_i        (clk),
    .rst_n_i      (rstN),
    .en_i         (en),
    .options_i    (options),
    .delay_len_i  (delayLen),
    .x_i          (x),
    .x_valid_i    (xValid),
    .ready_o      (ready),
    .y_o          (y),
    .y_valid_o    (yValid),
    .ram_we_o     (ramWe),
    .ram_addr_wr_o(ramAddrWr),
    .ram_addr_rd_o(ramAddrRd),
    .ram_di_o     (ramDi),
    .ram_do_i     (ramDo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM with registered read; read sees the old word on a same-edge write.
  always @(posedge clk) begin
    if (ramWe) mem[ramAddrWr] <= ramDi;
    ramDo <= mem[ramAddrRd];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] d);
    longint s;
    logic signed [31:0] half;
    half = $signed(d) >>> 1;
    s = longint'($signed(a)) + longint'(half);
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  task automatic monitorCycle();
    exp_t e;
    if (!clearing) begin
      checkOutput("rd_addr_range", 32'(int'(ramAddrRd) < T), 32'd1);
      if (!yValid) checkOutput("we_outside_wr", 32'(ramWe), 32'd0);
    end
    if (yValid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_y_valid", 32'(yValid), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("y", y, e.y);
        checkOutput("wr_we", 32'(ramWe), 32'(e.en));
        checkOutput("latency", 32'(cycleCnt - e.accN), 32'd2);
        if (e.en) begin
          checkOutput("wr_addr", 32'(ramAddrWr), 32'(e.wrAddr));
          checkOutput("wr_data", ramDi, e.wb);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycleCnt++;
    monitorCycle();
  endtask

  task automatic resetAndCheckClear();
    clearing = 1'b1;
    rstN = 1'b0;
    xValid = 1'b0;
    tick();
    tick();
    checkOutput("rst_we", 32'(ramWe), 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_y_valid", 32'(yValid), 32'd0);
    checkOutput("rst_y", y, 32'd0);
    hist.delete();
    ptrM = 0;
    rstN = 1'b1;
    for (int i = 0; i < T; i++) begin
      tick();
      checkOutput("clr_we", 32'(ramWe), 32'd1);
      checkOutput("clr_addr", 32'(ramAddrWr), 32'(i));
      checkOutput("clr_di", ramDi, 32'd0);
      checkOutput("clr_ready", 32'(ready), 32'd0);
      checkOutput("clr_y", y, 32'd0);
    end
    clearing = 1'b0;
    tick();
    checkOutput("clr_done_ready", 32'(ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] xIn, input bit enIn, input logic [3:0] optIn,
                               input int dlIn, input int lEff, input bit useTable,
                               input logic [31:0] tableY);
    exp_t e;
    logic [31:0] d, yM, wbM;
    int waitCnt;
    x = xIn;
    en = enIn;
    options = optIn;
    delayLen = B'(dlIn);
    xValid = 1'b1;
    waitCnt = 0;
    while (!ready && waitCnt < 64) begin
      tick();
      waitCnt++;
    end
    if (!ready) checkOutput("ready_timeout", 32'(ready), 32'd1);
    d = (hist.size() >= lEff) ? hist[hist.size() - lEff] : 32'd0;
    yM = xIn;
    wbM = xIn;
    if (enIn && (optIn == 4'b1000 || optIn == 4'b0100)) yM = satAdd(xIn, d);
    if (enIn && optIn == 4'b1000) wbM = yM;
    e.y = useTable ? tableY : yM;
    e.wb = wbM;
    e.en = enIn;
    e.wrAddr = ptrM;
    e.accN = cycleCnt + 1;
    sbQ.push_back(e);
    if (enIn) begin
      hist.push_back(wbM);
      ptrM = (ptrM + 1) % T;
    end
    tick();
    xValid = 1'b0;
    en = ~enIn;
    options = ~optIn;
    delayLen = B'($urandom);
    x = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbQ.size() > 0 && w < 64) begin
      tick();
      w++;
    end
    if (sbQ.size() > 0) begin
      checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
    end
  endtask

  function automatic vec_t mkVec(input bit rb, input logic [31:0] xv, input logic [3:0] o,
                                 input int dl, input int le, input logic [31:0] ey);
    vec_t v;
    v.resetBefore = rb;
    v.x = xv;
    v.en = 1'b1;
    v.opt = o;
    v.dl = dl;
    v.lEff = le;
    v.expY = ey;
    return v;
  endfunction

  initial begin
    int echoExp[12];
    int slapExp[8];
    logic [31:0] rx;
    errors = 0;
    checks = 0;
    cycleCnt = 0;
    ptrM = 0;
    clearing = 1'b1;
    rstN = 1'b0;
    en = 1'b0;
    options = 4'b0;
    delayLen = '0;
    x = '0;
    xValid = 1'b0;

    echoExp = '{1000, 0, 0, 500, 0, 0, 250, 0, 0, 125, 0, 0};
    slapExp = '{1000, 0, 0, 500, 0, 0, 0, 0};
    for (int n = 0; n < 12; n++)
      vecs.push_back(mkVec(n == 0, (n == 0) ? 32'd1000 : 32'd0, 4'b1000, 3, 3, 32'(echoExp[n])));
    for (int n = 0; n < 8; n++)
      vecs.push_back(mkVec(n == 0, (n == 0) ? 32'd1000 : 32'd0, 4'b0100, 3, 3, 32'(slapExp[n])));
    vecs.push_back(mkVec(1, 32'h7FFF_FFFE, 4'b0000, 1, 1, 32'h7FFF_FFFE));
    vecs.push_back(mkVec(0, 32'h7FFF_FFF0, 4'b1000, 1, 1, 32'h7FFF_FFFF));
    vecs.push_back(mkVec(0, 32'h8000_0000, 4'b0000, 1, 1, 32'h8000_0000));
    vecs.push_back(mkVec(0, 32'h8000_0000, 4'b1000, 1, 1, 32'h8000_0000));
    vecs.push_back(mkVec(0, 32'hFFFF_FC18, 4'b0000, 1, 1, 32'hFFFF_FC18));
    vecs.push_back(mkVec(0, 32'd100,       4'b1000, 1, 1, 32'hFFFF_FE70));
    vecs.push_back(mkVec(0, 32'hFFFF_FFFD, 4'b0000, 1, 1, 32'hFFFF_FFFD));
    vecs.push_back(mkVec(0, 32'd0,         4'b1000, 1, 1, 32'hFFFF_FFFE));
    vecs.push_back(mkVec(0, 32'd6,         4'b1100, 1, 1, 32'd6));
    vecs.push_back(mkVec(0, 32'd0,         4'b1000, 1, 1, 32'd3));

    resetAndCheckClear();

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].resetBefore) begin
        drain();
        resetAndCheckClear();
      end
      applyStimulus(vecs[i].x, vecs[i].en, vecs[i].opt, vecs[i].dl, vecs[i].lEff, 1'b1, vecs[i].expY);
    end
    drain();

    // Length 0 acts as 1 over 20 samples (pointer wraps twice), then 9 and 15 act as 8.
    resetAndCheckClear();
    for (int n = 0; n < 20; n++) begin
      rx = 32'($signed($urandom_range(0, 4000000)) - 2000000);
      applyStimulus(rx, 1'b1, 4'b1000, 0, 1, 1'b0, 32'd0);
    end
    for (int n = 0; n < 12; n++) begin
      rx = 32'($signed($urandom_range(0, 4000000)) - 2000000);
      applyStimulus(rx, 1'b1, 4'b1000, (n < 9) ? 9 : 15, 8, 1'b0, 32'd0);
    end
    drain();

    // Disabled samples pass through untouched; re-enabling picks up the old history.
    for (int n = 0; n < 5; n++)
      applyStimulus(32'(n * 37 + 11), 1'b0, 4'b1000, 1, 1, 1'b0, 32'd0);
    for (int n = 0; n < 5; n++)
      applyStimulus(32'(n * 5), 1'b1, 4'b1000, 1, 1, 1'b0, 32'd0);
    drain();

    // Reset while the sample is in MIX: no output strobe, full clear follows.
    applyStimulus(32'd4242, 1'b1, 4'b1000, 2, 2, 1'b0, 32'd0);
    void'(sbQ.pop_back());
    tick();
    resetAndCheckClear();
    applyStimulus(32'd50, 1'b1, 4'b1000, 1, 1, 1'b1, 32'd50);
    applyStimulus(32'd10, 1'b1, 4'b0100, 1, 1, 1'b1, 32'd35);
    drain();
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
